// File: rtl/hex_keypad_emulator_if.sv
// Request side of the hex keypad emulator: valid/ready press requests plus the
// completion pulse. The requester uses master, the emulator uses slave.
interface hex_keypad_emulator_if #(
  parameter int HOLD_W = 8
);
  logic              key_valid;
  logic [3:0]        key_code;
  logic [HOLD_W-1:0] key_hold;
  logic              key_ready;
  logic              done;

  modport master (
    output key_valid, key_code, key_hold,
    input  key_ready, done
  );

  modport slave (
    input  key_valid, key_code, key_hold,
    output key_ready, done
  );
endinterface

// File: rtl/hex_keypad_emulator.sv
// 4x4 hex keypad responder: turns a key-press request into a bouncing contact
// closure and senses the scanner's column drive onto the selected row.
module hex_keypad_emulator #(
  parameter int HOLD_W        = 8,
  parameter int BOUNCE_CYCLES = 4,
  parameter int GAP_CYCLES    = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  hex_keypad_emulator_if.slave req,
  input  logic [3:0]           Col,
  output logic [3:0]           Row,
  output logic                 S_Row,
  output logic                 pressed
);

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // The counter must reach hold-1 for the largest hold without wrapping.
  localparam int CNT_SPAN = max3(2**HOLD_W, BOUNCE_CYCLES, GAP_CYCLES);
  localparam int CNT_W    = (CNT_SPAN > 2) ? $clog2(CNT_SPAN) : 1;

  localparam logic [CNT_W-1:0] BOUNCE_LAST = CNT_W'(BOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MAKE,
    ST_HOLD,
    ST_BREAK,
    ST_GAP
  } state_t;

  state_t            state_q,   state_d;
  logic [3:0]        code_q,    code_d;
  logic [HOLD_W-1:0] hold_q,    hold_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  logic              contact_q, contact_d;
  logic              s_row_q,   s_row_d;
  logic              done_q,    done_d;

  logic [CNT_W-1:0]  hold_last;

  assign hold_last = CNT_W'(hold_q) - CNT_W'(1);

  // cnt_q is the index of the current cycle within the current state; every
  // register describes the cycle that follows the next rising edge.
  // NOTE: always_comb assigns every output a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    hold_d    = hold_q;
    cnt_d     = cnt_q;
    contact_d = contact_q;

    case (state_q)
      ST_IDLE: begin
        contact_d = 1'b0;
        if (req.key_valid) begin
          code_d    = req.key_code;
          hold_d    = (req.key_hold == '0) ? HOLD_W'(1) : req.key_hold;
          cnt_d     = '0;
          contact_d = 1'b1;
          state_d   = (BOUNCE_CYCLES > 0) ? ST_MAKE : ST_HOLD;
        end
      end

      ST_MAKE: begin
        if (cnt_q == BOUNCE_LAST) begin
          cnt_d     = '0;
          contact_d = 1'b1;
          state_d   = ST_HOLD;
        end else begin
          cnt_d     = cnt_q + CNT_W'(1);
          contact_d = cnt_q[0];          // closed on even cycle indices
        end
      end

      ST_HOLD: begin
        if (cnt_q == hold_last) begin
          cnt_d     = '0;
          contact_d = 1'b0;
          state_d   = (BOUNCE_CYCLES > 0) ? ST_BREAK : ST_GAP;
        end else begin
          cnt_d     = cnt_q + CNT_W'(1);
          contact_d = 1'b1;
        end
      end

      ST_BREAK: begin
        if (cnt_q == BOUNCE_LAST) begin
          cnt_d     = '0;
          contact_d = 1'b0;
          state_d   = ST_GAP;
        end else begin
          cnt_d     = cnt_q + CNT_W'(1);
          contact_d = ~cnt_q[0];         // open on even cycle indices
        end
      end

      ST_GAP: begin
        contact_d = 1'b0;
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        cnt_d     = '0;
        contact_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase

    done_d = (state_d == ST_GAP) && (cnt_d == GAP_LAST);
  end

  // Row sensing is purely combinational so the scanner sees its column drive
  // reflected in the same cycle.
  always_comb begin
    Row = 4'b0000;
    if (contact_q && Col[code_q[1:0]]) begin
      Row = 4'b0001 << code_q[3:2];
    end
    s_row_d = |Row;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of evaluation order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      code_q    <= '0;
      hold_q    <= '0;
      cnt_q     <= '0;
      contact_q <= 1'b0;
      s_row_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      hold_q    <= hold_d;
      cnt_q     <= cnt_d;
      contact_q <= contact_d;
      s_row_q   <= s_row_d;
      done_q    <= done_d;
    end
  end

  assign req.key_ready = (state_q == ST_IDLE);
  assign req.done      = done_q;
  assign S_Row         = s_row_q;
  assign pressed       = contact_q;

endmodule

// File: tb/tb_hex_keypad_emulator.sv
// Self-checking bench for hex_keypad_emulator: a queue-based contact model
// checked every cycle, plus directed literal checks and a zero-bounce instance.
module tb_hex_keypad_emulator;

  localparam int HOLD_W = 8;
  localparam int B      = 4;
  localparam int G      = 8;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  hex_keypad_emulator_if #(.HOLD_W(HOLD_W)) req ();
  logic [3:0] col, row;
  logic       s_row, pressed;

  hex_keypad_emulator #(.HOLD_W(HOLD_W), .BOUNCE_CYCLES(B), .GAP_CYCLES(G)) dut (
    .clock   (clock),
    .reset   (reset),
    .req     (req),
    .Col     (col),
    .Row     (row),
    .S_Row   (s_row),
    .pressed (pressed)
  );

  // Second instance: no bounce, two gap cycles.
  hex_keypad_emulator_if #(.HOLD_W(4)) req1 ();
  logic [3:0] col1, row1;
  logic       s_row1, pressed1;

  hex_keypad_emulator #(.HOLD_W(4), .BOUNCE_CYCLES(0), .GAP_CYCLES(2)) dut1 (
    .clock   (clock),
    .reset   (reset),
    .req     (req1),
    .Col     (col1),
    .Row     (row1),
    .S_Row   (s_row1),
    .pressed (pressed1)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the contact value of every remaining cycle of the current
  // press sits in a queue, front = current cycle; empty queue = idle.
  bit         exp_q[$];
  logic [3:0] m_code     = 4'd0;
  logic       m_srow     = 1'b0;
  logic [3:0] m_row_last = 4'd0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      exp_q.delete();
      m_code = 4'd0;
      m_srow = 1'b0;
    end else begin
      int h;
      m_srow = |m_row_last;
      if (exp_q.size() > 0) begin
        void'(exp_q.pop_front());
      end else if (req.key_valid) begin
        m_code = req.key_code;
        h = (req.key_hold == 0) ? 1 : int'(req.key_hold);
        for (int i = 0; i < B; i++) exp_q.push_back(i % 2 == 0);
        for (int i = 0; i < h; i++) exp_q.push_back(1'b1);
        for (int i = 0; i < B; i++) exp_q.push_back(i % 2 == 1);
        for (int i = 0; i < G; i++) exp_q.push_back(1'b0);
      end
    end
  end

  always @(negedge clock) begin
    bit         c;
    logic [3:0] e_row;
    c = (exp_q.size() > 0) ? exp_q[0] : 1'b0;
    e_row = (c && col[m_code[1:0]]) ? (4'b0001 << m_code[3:2]) : 4'b0000;
    m_row_last = e_row;
    check("row",       row,           e_row);
    check("s_row",     s_row,         m_srow);
    check("pressed",   pressed,       c);
    check("done",      req.done,      exp_q.size() == 1);
    check("key_ready", req.key_ready, exp_q.size() == 0);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Raise a request and return in the first cycle after the accepting edge.
  task automatic press(input logic [3:0] code, input int hold, input bit keep);
    bit ok = 1'b0;
    req.key_valid = 1'b1;
    req.key_code  = code;
    req.key_hold  = HOLD_W'(hold);
    for (int n = 0; n < 2000 && !ok; n++) begin
      @(negedge clock);
      ok = req.key_ready;
      @(posedge clock);
      #1;
    end
    check("accept", ok, 1'b1);
    if (!keep) req.key_valid = 1'b0;
  endtask

  // Count cycles up to and including the done pulse, shifting in pressed.
  task automatic count_to_done(output int n, output logic [31:0] ph, output logic [3:0] r1);
    n  = 0;
    ph = '0;
    r1 = '0;
    do begin
      @(negedge clock);
      n++;
      ph = {ph[30:0], pressed};
      if (n == 1) r1 = row;
    end while (!req.done && n < 1000);
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    bit          ok;
    logic [31:0] ph, dh, sh;
    logic [3:0]  r1;
    logic [3:0]  cols [4];
    logic [3:0]  rexp [4];

    reset          = 1'b1;
    req.key_valid  = 1'b0;
    req.key_code   = 4'd0;
    req.key_hold   = '0;
    col            = 4'b0000;
    req1.key_valid = 1'b0;
    req1.key_code  = 4'd0;
    req1.key_hold  = '0;
    col1           = 4'b1111;

    repeat (3) step();
    @(negedge clock);
    check("rst_ready",   req.key_ready, 1'b1);
    check("rst_row",     row,           4'b0000);
    check("rst_pressed", pressed,       1'b0);
    check("rst_done",    req.done,      1'b0);
    check("rst_s_row",   s_row,         1'b0);
    step();
    reset = 1'b0;
    step();

    // Zero-bounce instance: hold 3, gap 2 -> 1,1,1,0,0 with done on the fifth.
    req1.key_valid = 1'b1;
    req1.key_code  = 4'd1;
    req1.key_hold  = 4'd3;
    @(negedge clock);
    check("nb_ready0", req1.key_ready, 1'b1);
    step();
    req1.key_valid = 1'b0;
    ph = '0; dh = '0; sh = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      ph = {ph[30:0], pressed1};
      dh = {dh[30:0], req1.done};
      sh = {sh[30:0], s_row1};
      if (i == 0) r1 = row1;
    end
    check("nb_pressed", ph[4:0], 5'b11100);
    check("nb_done",    dh[4:0], 5'b00001);
    check("nb_s_row",   sh[4:0], 5'b01110);
    check("nb_row",     r1,      4'b0001);
    @(negedge clock);
    check("nb_ready1", req1.key_ready, 1'b1);
    step();

    // Code 6, Col 0100: row index 1 -> Row 0010 in the first make cycle.
    press(4'd6, 10, 1'b0);
    col = 4'b0100;
    count_to_done(n, ph, r1);
    check("c6_row",     r1,       4'b0010);
    check("c6_len",     n,        26);
    check("c6_pattern", ph[25:0], 26'b10101111111111010100000000);

    // Column selectivity, code 11 (row 2, col 3) in the hold phase.
    cols = '{4'b0001, 4'b0100, 4'b0010, 4'b1000};
    rexp = '{4'b0000, 4'b0000, 4'b0000, 4'b0100};
    press(4'd11, 20, 1'b0);
    repeat (4) step();
    for (int i = 0; i < 4; i++) begin
      col = cols[i];
      @(negedge clock);
      check("col_sel", row, rexp[i]);
      step();
    end
    count_to_done(n, ph, r1);
    check("c11_rest", n, 28);

    // Reset in the middle of hold: Row clears in the same cycle.
    press(4'd5, 20, 1'b0);
    col = 4'b0010;
    repeat (6) step();
    #1;
    check("pre_rst_row", row, 4'b0010);
    reset = 1'b1;
    #1;
    check("rst_row_now", row, 4'b0000);
    step();
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_ready", req.key_ready, 1'b1);
    check("post_rst_s_row", s_row,         1'b0);
    step();

    // Hold 0 behaves as hold 1.
    col = 4'b1111;
    press(4'd9, 0, 1'b0);
    count_to_done(n, ph, r1);
    check("h0_len",     n,        17);
    check("h0_pattern", ph[16:0], 17'b10101010100000000);

    // Largest hold must not wrap the counter.
    press(4'd15, 255, 1'b0);
    count_to_done(n, ph, r1);
    check("hmax_len", n, 2 * B + 255 + G);

    // Back-to-back with key_valid held; request inputs change after accept.
    press(4'd3, 2, 1'b1);
    req.key_code = 4'd12;
    req.key_hold = HOLD_W'(5);
    n  = 1;
    ok = 1'b0;
    @(negedge clock);
    while (!ok && n < 200) begin
      @(negedge clock);
      if (req.key_ready) ok = 1'b1;
      else n++;
    end
    check("b2b_busy", n, 18);
    step();
    @(negedge clock);
    check("b2b_reaccept", req.key_ready, 1'b0);
    req.key_valid = 1'b0;
    count_to_done(n, ph, r1);
    check("b2b_second_len", n, 20);

    // Randomised traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      req.key_valid = ($urandom_range(0, 3) == 0);
      req.key_code  = 4'($urandom);
      req.key_hold  = HOLD_W'($urandom_range(0, 12));
      col           = ($urandom_range(0, 4) == 0) ? 4'b1111 : 4'($urandom);
      step();
    end
    req.key_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clock);
      ok = req.key_ready;
    end
    check("final_idle", ok, 1'b1);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
